// File: rtl/fwrisc_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch port and the load/store data port.
// Define FWRISC_MEM_ARB_TIMEOUT_EN to abort a grant after TIMEOUT_CYCLES cycles without mready.
module fwrisc_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic        iready,
  output logic [31:0] idata,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic        dready,
  output logic [31:0] drdata,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mwstb,
  output logic        mwrite,
  output logic        mvalid,
  input  logic        mready,
  input  logic [31:0] mrdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e state_r;
  state_e next_state_s;
  logic   last_gnt_d_r;
  logic   gnt_s;
  logic   timeout_s;
  logic   done_s;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fwrisc_mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  assign gnt_s  = (state_r == GNT_I) || (state_r == GNT_D);
  assign done_s = gnt_s && (mready || timeout_s);

`ifdef FWRISC_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_r;

  // Fires on the TIMEOUT_CYCLES-th grant cycle that still has no mready
  assign timeout_s = gnt_s && !mready && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts grant cycles spent waiting for mready; cleared whenever the bus is idle
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (!gnt_s) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (!mready) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: on a tie the port that did not win last time is granted
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (dvalid && (!ivalid || !last_gnt_d_r)) begin
          next_state_s = GNT_D;
        end else if (ivalid) begin
          next_state_s = GNT_I;
        end else begin
          next_state_s = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (done_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Completion pulses are combinational from mready so no response latency is added
  always_comb begin
    iready  = 1'b0;
    dready  = 1'b0;
    bus_err = timeout_s;
    if (timeout_s) begin
      idata  = 32'h0000_0000;
      drdata = 32'h0000_0000;
    end else begin
      idata  = mrdata;
      drdata = mrdata;
    end
    case (state_r)
      GNT_I:   iready = done_s;
      GNT_D:   dready = done_s;
      default: begin
        iready = 1'b0;
        dready = 1'b0;
      end
    endcase
  end

  // Memory request registers: loaded from the winner on grant, held until completion
  always_ff @(posedge clock) begin
    if (reset) begin
      maddr        <= 32'h0000_0000;
      mwdata       <= 32'h0000_0000;
      mwstb        <= 4'h0;
      mwrite       <= 1'b0;
      mvalid       <= 1'b0;
      last_gnt_d_r <= 1'b0;
    end else if ((state_r == IDLE) && (next_state_s == GNT_D)) begin
      maddr  <= daddr;
      mwdata <= dwdata;
      mwstb  <= dwstb;
      mwrite <= dwrite;
      mvalid <= 1'b1;
    end else if ((state_r == IDLE) && (next_state_s == GNT_I)) begin
      maddr  <= iaddr;
      mwdata <= 32'h0000_0000;
      mwstb  <= 4'h0;
      mwrite <= 1'b0;
      mvalid <= 1'b1;
    end else if (done_s) begin
      mvalid       <= 1'b0;
      last_gnt_d_r <= (state_r == GNT_D);
    end
  end

endmodule
